// File: rtl/point_display.sv
`default_nettype none
// point_display: one decimal digit (0-9) with seven-segment decode and a carry out for chaining.
// Define POINT_DISPLAY_ACTIVE_HIGH_EN to drive the segments active-high instead of active-low.
module point_display (
  input  logic       clk,
  input  logic       reset,
  input  logic       upCount,
  output logic [6:0] hex,
  output logic       nextHex
);

  logic [3:0] digit;
  logic [6:0] seg_low;

  // Out-of-range encodings recover to 0 on the next edge, whether or not upCount is set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit <= 4'd0;
    end else if (digit > 4'd9) begin
      digit <= 4'd0;
    end else if (upCount) begin
      digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    end
  end

  // Active-low patterns, bit order g f e d c b a.
  always_comb begin
    seg_low = 7'h40;
    case (digit)
      4'd0:    seg_low = 7'h40;
      4'd1:    seg_low = 7'h79;
      4'd2:    seg_low = 7'h24;
      4'd3:    seg_low = 7'h30;
      4'd4:    seg_low = 7'h19;
      4'd5:    seg_low = 7'h12;
      4'd6:    seg_low = 7'h02;
      4'd7:    seg_low = 7'h78;
      4'd8:    seg_low = 7'h00;
      4'd9:    seg_low = 7'h10;
      default: seg_low = 7'h40;
    endcase
  end

`ifdef POINT_DISPLAY_ACTIVE_HIGH_EN
  assign hex = ~seg_low;
`else
  assign hex = seg_low;
`endif

  assign nextHex = upCount & (digit == 4'd9);

endmodule
`default_nettype wire

// File: tb/tb_point_display.sv
`default_nettype none
// Testbench: two chained point_display digits checked against a scoreboard of expected patterns.
module tb_point_display;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       upCount = 1'b0;
  logic [6:0] hex_lo, hex_hi;
  logic       carry, carry_hi;

  int checks = 0;
  int errors = 0;
  int carries = 0;
  int m_lo = 0;
  int m_hi = 0;
  logic [13:0] exp_q[$];

  point_display u_lo (
    .clk     (clk),
    .reset   (reset),
    .upCount (upCount),
    .hex     (hex_lo),
    .nextHex (carry)
  );

  point_display u_hi (
    .clk     (clk),
    .reset   (reset),
    .upCount (carry),
    .hex     (hex_hi),
    .nextHex (carry_hi)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  function automatic logic [6:0] seg(input int d);
    logic [6:0] s;
    case (d)
      0: s = 7'h40;
      1: s = 7'h79;
      2: s = 7'h24;
      3: s = 7'h30;
      4: s = 7'h19;
      5: s = 7'h12;
      6: s = 7'h02;
      7: s = 7'h78;
      8: s = 7'h00;
      9: s = 7'h10;
      default: s = 7'h40;
    endcase
`ifdef POINT_DISPLAY_ACTIVE_HIGH_EN
    return ~s;
`else
    return s;
`endif
  endfunction

  task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge: drive upCount, check carry, then check digits after the next edge.
  task automatic drive(input logic up);
    logic exp_carry;
    upCount = up;
    #1;
    exp_carry = up && (m_lo == 9);
    chk("carry", {13'd0, carry}, {13'd0, exp_carry});
    if (carry === 1'b1) carries++;
    if (up) begin
      if (m_lo == 9) m_hi = (m_hi + 1) % 10;
      m_lo = (m_lo + 1) % 10;
    end
    exp_q.push_back({seg(m_hi), seg(m_lo)});
    @(posedge clk);
    #1;
    chk("digits", {hex_hi, hex_lo}, exp_q.pop_front());
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    upCount = 1'b0;
    m_lo = 0;
    m_hi = 0;
    exp_q.delete();
    #1;
    chk("reset_hex", {hex_hi, hex_lo}, {seg(0), seg(0)});
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held low; upCount must be ignored across an edge.
    reset = 1'b0;
    upCount = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_hold_hex", {hex_hi, hex_lo}, {seg(0), seg(0)});
    chk("reset_hold_carry", {13'd0, carry}, 14'd0);
    @(negedge clk);
    upCount = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Idle cycles after reset release.
    for (int i = 0; i < 3; i++) drive(1'b0);

    // Alternating pulses: 11 increments end at digit 1 of the low digit.
    carries = 0;
    for (int i = 0; i < 11; i++) begin
      drive(1'b1);
      drive(1'b0);
    end
    chk("alt_final", {7'd0, hex_lo}, {7'd0, seg(1)});
    chk("alt_carries", 14'(carries), 14'd1);

    // Continuous count: ten edges wrap the low digit and bump the upper one together.
    do_reset();
    carries = 0;
    for (int i = 0; i < 10; i++) drive(1'b1);
    chk("run_final", {hex_hi, hex_lo}, {seg(1), seg(0)});
    chk("run_carries", 14'(carries), 14'd1);

    // Asynchronous reset between edges at digit 7, with an increment pending.
    do_reset();
    for (int i = 0; i < 7; i++) drive(1'b1);
    chk("at_seven", {7'd0, hex_lo}, {7'd0, seg(7)});
    upCount = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("async_clear", {hex_hi, hex_lo}, {seg(0), seg(0)});
    chk("async_carry", {13'd0, carry}, 14'd0);
    @(posedge clk);
    #1;
    chk("pending_discarded", {hex_hi, hex_lo}, {seg(0), seg(0)});
    @(negedge clk);
    reset = 1'b1;
    m_lo = 0;
    m_hi = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("post_release", {7'd0, hex_lo}, {7'd0, seg(1)});
    m_lo = 1;

    // One more increment then hold.
    drive(1'b1);
    drive(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
